// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the N-way intersection controller.
// The optional night mode (SEMAFORO_NOCTURNO_EN) uses the NOCHE state declared here.
package semaforo_pkg;

  typedef enum logic [2:0] {
    ROJO_AMARILLO = 3'd0,
    VERDE         = 3'd1,
    AMARILLO      = 3'd2,
    TODO_ROJO     = 3'd3,
    NOCHE         = 3'd4
  } estado_t;

  // Bits needed to count 0..max(T)-1, never narrower than one bit.
  function automatic int timer_width(int t_ra, int t_verde, int t_amar, int t_tr);
    int m;
    m = t_ra;
    if (t_verde > m) m = t_verde;
    if (t_amar > m) m = t_amar;
    if (t_tr > m) m = t_tr;
    if (m > 1) return $clog2(m);
    else return 1;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: produces a one-cycle tick every DIVISOR clk cycles.
module divisor_tick #(
  parameter int unsigned DIVISOR = 500000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIVISOR - 1));

  always_comb begin
    if (tick) cnt_d = '0;
    else cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/semaforo_cruce_chk.sv
// Lamp safety properties for semaforo_cruce: one green at most, never green with red on a via.
module semaforo_cruce_chk #(
  parameter int unsigned NUM_VIAS = 2
) (
  input logic                clk,
  input logic                rst,
  input logic [NUM_VIAS-1:0] rojo,
  input logic [NUM_VIAS-1:0] verde
);

  a_verde_unico: assert property (@(posedge clk) disable iff (rst) $onehot0(verde))
    else $error("more than one green lamp: %b", verde);

  a_verde_rojo: assert property (@(posedge clk) disable iff (rst) ((verde & rojo) == '0))
    else $error("green and red together: verde=%b rojo=%b", verde, rojo);

endmodule

// File: rtl/semaforo_cruce.sv
// N-way round-robin intersection controller with demand skipping and all-red clearance.
// Define SEMAFORO_NOCTURNO_EN to add the NOCHE (flashing amber) night mode.
module semaforo_cruce
  import semaforo_pkg::*;
#(
  parameter int unsigned NUM_VIAS = 2,
  parameter int unsigned DIVISOR  = 500000,
  parameter int unsigned T_RA     = 1,
  parameter int unsigned T_VERDE  = 4,
  parameter int unsigned T_AMAR   = 2,
  parameter int unsigned T_TR     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_VIAS-1:0]         peticion,
  input  logic                        nocturno,
  output logic [NUM_VIAS-1:0]         rojo,
  output logic [NUM_VIAS-1:0]         amarillo,
  output logic [NUM_VIAS-1:0]         verde,
  output logic [$clog2(NUM_VIAS)-1:0] via_activa
);

  localparam int VW = $clog2(NUM_VIAS);
  localparam int NV = int'(NUM_VIAS);
  localparam int TW = timer_width(int'(T_RA), int'(T_VERDE), int'(T_AMAR), int'(T_TR));

  estado_t               estado_q, estado_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [VW-1:0]         via_q, via_d;
  logic [NUM_VIAS-1:0]   demanda_q, demanda_d;
  logic [NUM_VIAS-1:0]   clr_s;
  logic [VW-1:0]         sel_s, idx_s;
  logic                  hallada_s, tick_s, fin_s, entra_ra_s;
  logic                  noche_req_s, ir_noche_s;

  divisor_tick #(.DIVISOR(DIVISOR)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  function automatic int duracion(estado_t s);
    case (s)
      ROJO_AMARILLO: return int'(T_RA);
      VERDE:         return int'(T_VERDE);
      AMARILLO:      return int'(T_AMAR);
      TODO_ROJO:     return int'(T_TR);
      default:       return 1;
    endcase
  endfunction

  assign fin_s = (timer_q == TW'(duracion(estado_q) - 1));

`ifdef SEMAFORO_NOCTURNO_EN
  logic blink_q, blink_d, noche_pend_q, noche_pend_d;

  assign noche_req_s = nocturno;
  assign ir_noche_s  = noche_pend_q | nocturno;

  // A night request is remembered until NOCHE is reached; amber flashes on every tick.
  always_comb begin
    noche_pend_d = noche_pend_q;
    blink_d      = blink_q;
    if (estado_d == NOCHE && estado_q != NOCHE) begin
      blink_d      = 1'b1;
      noche_pend_d = 1'b0;
    end else if (estado_q == NOCHE) begin
      if (tick_s) blink_d = ~blink_q;
      else blink_d = blink_q;
    end else if (nocturno) begin
      noche_pend_d = 1'b1;
    end else begin
      noche_pend_d = noche_pend_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q      <= 1'b0;
      noche_pend_q <= 1'b0;
    end else begin
      blink_q      <= blink_d;
      noche_pend_q <= noche_pend_d;
    end
  end
`else
  logic unused_nocturno;
  assign unused_nocturno = nocturno;
  assign noche_req_s     = 1'b0;
  assign ir_noche_s      = 1'b0;
`endif

  // Round-robin search starting after the current via; the current via is tried last.
  always_comb begin
    sel_s     = VW'((int'(via_q) + 1) % NV);
    idx_s     = '0;
    hallada_s = 1'b0;
    for (int k = 1; k <= NV; k++) begin
      idx_s = VW'((int'(via_q) + k) % NV);
      if (!hallada_s && demanda_q[idx_s]) begin
        sel_s     = idx_s;
        hallada_s = 1'b1;
      end else begin
        hallada_s = hallada_s;
      end
    end
  end

  always_comb begin
    estado_d   = estado_q;
    timer_d    = timer_q;
    via_d      = via_q;
    entra_ra_s = 1'b0;
    if (noche_req_s && estado_q == VERDE) begin
      estado_d = AMARILLO;
      timer_d  = '0;
    end else if (noche_req_s && estado_q == ROJO_AMARILLO) begin
      estado_d = TODO_ROJO;
      timer_d  = '0;
    end else if (tick_s) begin
      if (fin_s) begin
        timer_d = '0;
        case (estado_q)
          ROJO_AMARILLO: estado_d = VERDE;
          VERDE:         estado_d = AMARILLO;
          AMARILLO:      estado_d = TODO_ROJO;
          TODO_ROJO: begin
            if (ir_noche_s) begin
              estado_d = NOCHE;
            end else begin
              estado_d   = ROJO_AMARILLO;
              via_d      = sel_s;
              entra_ra_s = 1'b1;
            end
          end
          NOCHE: begin
            if (noche_req_s) estado_d = NOCHE;
            else estado_d = TODO_ROJO;
          end
          default: estado_d = TODO_ROJO;
        endcase
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = timer_q;
    end
  end

  // Clearing on RA entry overrides a request arriving on the same edge.
  always_comb begin
    clr_s = '0;
    if (entra_ra_s) clr_s[via_d] = 1'b1;
    else clr_s = '0;
    demanda_d = (demanda_q | peticion) & ~clr_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= TODO_ROJO;
      timer_q   <= '0;
      via_q     <= VW'(NUM_VIAS - 1);
      demanda_q <= '0;
    end else begin
      estado_q  <= estado_d;
      timer_q   <= timer_d;
      via_q     <= via_d;
      demanda_q <= demanda_d;
    end
  end

  always_comb begin
    rojo     = '1;
    amarillo = '0;
    verde    = '0;
    case (estado_q)
      ROJO_AMARILLO: amarillo[via_q] = 1'b1;
      VERDE: begin
        rojo[via_q]  = 1'b0;
        verde[via_q] = 1'b1;
      end
      AMARILLO: begin
        rojo[via_q]     = 1'b0;
        amarillo[via_q] = 1'b1;
      end
`ifdef SEMAFORO_NOCTURNO_EN
      NOCHE: begin
        rojo     = '0;
        amarillo = {NUM_VIAS{blink_q}};
      end
`endif
      default: rojo = '1;
    endcase
  end

  assign via_activa = via_q;

endmodule

// File: tb/tb_semaforo_cruce.sv
// Self-checking bench: period-position model for DIVISOR=1 plus directed literal checks (DIVISOR=1 and 4).
module tb_semaforo_cruce;

  localparam int N    = 3;
  localparam int TRA  = 1;
  localparam int TV   = 4;
  localparam int TA   = 2;
  localparam int TTR  = 1;
  localparam int P    = TRA + TV + TA + TTR;

  logic clk, rst, rst4, noct, run_cmp;
  logic [N-1:0] pet, pet4;
  logic [N-1:0] r, a, g, r4, a4, g4;
  logic [1:0]   v, v4;

  int checks = 0;
  int errors = 0;
  int tk = 0;

  semaforo_cruce #(.NUM_VIAS(N), .DIVISOR(1), .T_RA(TRA), .T_VERDE(TV), .T_AMAR(TA), .T_TR(TTR)) dut (
    .clk(clk), .rst(rst), .peticion(pet), .nocturno(noct),
    .rojo(r), .amarillo(a), .verde(g), .via_activa(v));

  semaforo_cruce #(.NUM_VIAS(N), .DIVISOR(4), .T_RA(TRA), .T_VERDE(TV), .T_AMAR(TA), .T_TR(TTR)) dut4 (
    .clk(clk), .rst(rst4), .peticion(pet4), .nocturno(noct),
    .rojo(r4), .amarillo(a4), .verde(g4), .via_activa(v4));

  semaforo_cruce_chk #(.NUM_VIAS(N)) u_chk  (.clk(clk), .rst(rst),  .rojo(r),  .verde(g));
  semaforo_cruce_chk #(.NUM_VIAS(N)) u_chk4 (.clk(clk), .rst(rst4), .rojo(r4), .verde(g4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each service window is P ticks long (RA, VERDE, AMARILLO, TR in that order).
  int m_v, m_pos;
  logic [N-1:0] m_dem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v   = N - 1;
      m_pos = P - TTR;
      m_dem = '0;
    end else begin
      logic [N-1:0] nd;
      int nv;
      nd    = m_dem | pet;
      m_pos = m_pos + 1;
      if (m_pos == P) begin
        m_pos = 0;
        nv    = -1;
        for (int k = 1; k <= N; k++)
          if (nv < 0 && m_dem[(m_v + k) % N]) nv = (m_v + k) % N;
        if (nv < 0) nv = (m_v + 1) % N;
        m_v     = nv;
        nd[nv]  = 1'b0;
      end
      m_dem = nd;
    end
  end

  always @(negedge clk) begin
    if (!rst && run_cmp) begin
      logic [N-1:0] er, ea, eg;
      er = '1; ea = '0; eg = '0;
      if (m_pos < TRA) ea[m_v] = 1'b1;
      else if (m_pos < TRA + TV) begin eg[m_v] = 1'b1; er[m_v] = 1'b0; end
      else if (m_pos < TRA + TV + TA) begin ea[m_v] = 1'b1; er[m_v] = 1'b0; end
      chk("model_rojo", 8'(r), 8'(er));
      chk("model_amarillo", 8'(a), 8'(ea));
      chk("model_verde", 8'(g), 8'(eg));
      chk("model_via", 8'(v), 8'(m_v));
      chk("verde_onehot", {7'd0, $onehot0(g)}, 8'd1);
      chk("verde_y_rojo", 8'(g & r), 8'd0);
    end
  end

  initial begin
    rst = 1'b1; rst4 = 1'b1; noct = 1'b0; run_cmp = 1'b0;
    pet = '0; pet4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_rojo", 8'(r), 8'h07);
    chk("rst_amarillo", 8'(a), 8'h00);
    chk("rst_verde", 8'(g), 8'h00);
    chk("rst_via", 8'(v), 8'd2);
    chk("rst4_rojo", 8'(r4), 8'h07);
    chk("rst4_via", 8'(v4), 8'd2);
    rst = 1'b0; rst4 = 1'b0; run_cmp = 1'b1;

    for (int e = 1; e <= 58; e++) begin
      @(negedge clk);
      if (e <= 20 && dut4.tick_s) tk++;
      case (e)
        1:  begin chk("e1_via", 8'(v), 8'd0); chk("e1_amar", 8'(a), 8'h01); chk("e1_rojo", 8'(r), 8'h07);
                  chk("d4_e1_rojo", 8'(r4), 8'h07); chk("d4_e1_via", 8'(v4), 8'd2); end
        2:  begin chk("e2_verde", 8'(g), 8'h01); chk("e2_rojo", 8'(r), 8'h06); end
        3:  begin chk("d4_e3_rojo", 8'(r4), 8'h07); chk("d4_e3_amar", 8'(a4), 8'h00); end
        4:  begin chk("d4_e4_via", 8'(v4), 8'd0); chk("d4_e4_amar", 8'(a4), 8'h01); end
        6:  begin chk("e6_amar", 8'(a), 8'h01); chk("e6_rojo", 8'(r), 8'h06); end
        7:  chk("d4_e7_amar", 8'(a4), 8'h01);
        8:  begin chk("e8_rojo", 8'(r), 8'h07); chk("e8_amar", 8'(a), 8'h00); chk("e8_via", 8'(v), 8'd0);
                  chk("d4_e8_verde", 8'(g4), 8'h01); end
        9:  begin chk("e9_via", 8'(v), 8'd1); chk("e9_amar", 8'(a), 8'h02); end
        17: begin chk("e17_via", 8'(v), 8'd2); chk("e17_amar", 8'(a), 8'h04); end
        20: chk("d4_tick_count", 8'(tk), 8'd5);
        23: chk("d4_e23_verde", 8'(g4), 8'h01);
        24: begin chk("d4_e24_amar", 8'(a4), 8'h01); chk("d4_e24_rojo", 8'(r4), 8'h06); end
        25: begin chk("e25_wrap_via", 8'(v), 8'd0); chk("e25_amar", 8'(a), 8'h01); end
        26: pet = 3'b100;
        27: pet = 3'b000;
        33: begin chk("skip_via", 8'(v), 8'd2); chk("skip_amar", 8'(a), 8'h04);
                  chk("skip_dem_clear", 8'(dut.demanda_q), 8'h00); end
        36: begin chk("d4_e36_via", 8'(v4), 8'd1); chk("d4_e36_amar", 8'(a4), 8'h02); end
        40: pet = 3'b001;
        41: begin pet = 3'b000; chk("clrwins_via", 8'(v), 8'd0);
                  chk("clrwins_dem0", {7'd0, dut.demanda_q[0]}, 8'd0); end
        49: begin chk("fixed_via", 8'(v), 8'd1); chk("fixed_amar", 8'(a), 8'h02); end
        50: pet = 3'b010;
        51: pet = 3'b000;
        57: begin chk("self_via", 8'(v), 8'd1); chk("self_amar", 8'(a), 8'h02); end
        58: chk("e58_verde", 8'(g), 8'h02);
        default: ;
      endcase
    end

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rojo", 8'(r), 8'h07);
    chk("midrst_amar", 8'(a), 8'h00);
    chk("midrst_verde", 8'(g), 8'h00);
    chk("midrst_via", 8'(v), 8'd2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_via", 8'(v), 8'd0);
    chk("restart_amar", 8'(a), 8'h01);
    @(negedge clk);
`ifdef SEMAFORO_NOCTURNO_EN
    run_cmp = 1'b0;
    noct = 1'b1;
    @(negedge clk);
    chk("n3_amar", 8'(a), 8'h01); chk("n3_rojo", 8'(r), 8'h06); chk("n3_verde", 8'(g), 8'h00);
    @(negedge clk);
    chk("n4_amar", 8'(a), 8'h01);
    @(negedge clk);
    chk("n5_rojo", 8'(r), 8'h07); chk("n5_amar", 8'(a), 8'h00);
    @(negedge clk);
    chk("n6_amar", 8'(a), 8'h07); chk("n6_rojo", 8'(r), 8'h00); chk("n6_verde", 8'(g), 8'h00);
    @(negedge clk);
    chk("n7_amar", 8'(a), 8'h00); chk("n7_rojo", 8'(r), 8'h00);
    @(negedge clk);
    chk("n8_amar", 8'(a), 8'h07);
    noct = 1'b0;
    @(negedge clk);
    chk("n9_rojo", 8'(r), 8'h07); chk("n9_amar", 8'(a), 8'h00); chk("n9_via", 8'(v), 8'd0);
    @(negedge clk);
    chk("n10_via", 8'(v), 8'd1); chk("n10_amar", 8'(a), 8'h02);
`else
    repeat (30) @(negedge clk);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
